// File: rtl/clockbox_mode_ctrl.sv
// Front-panel controller for the clockbox: conditions the mode/power/start/stop buttons
// and runs the display-mode and chronometer state machines. Holds no time values.
module clockbox_mode_ctrl #(
    parameter int unsigned CLK_HZ         = 10000,
    parameter int unsigned DEBOUNCE_CYC   = 100,
    parameter int unsigned LONG_PRESS_CYC = 20000
) (
    input  logic clock,
    input  logic reset,
    input  logic btn_mode,
    input  logic btn_power,
    input  logic btn_start,
    input  logic btn_stop,
    output logic disp_en,
    output logic disp_mode,
    output logic disp_page,
    output logic chrono_run,
    output logic chrono_clear
);

    localparam int unsigned DbW = $clog2(DEBOUNCE_CYC);
    localparam int unsigned LpW = $clog2(LONG_PRESS_CYC + 1);
    localparam logic [DbW-1:0] DbLast = DbW'(DEBOUNCE_CYC - 1);
    localparam logic [LpW-1:0] LpMax  = LpW'(LONG_PRESS_CYC);
    localparam logic [LpW-1:0] LpLast = LpW'(LONG_PRESS_CYC - 1);

    localparam int unsigned BMode  = 0;
    localparam int unsigned BPower = 1;
    localparam int unsigned BStart = 2;
    localparam int unsigned BStop  = 3;

    if (CLK_HZ == 0 || DEBOUNCE_CYC < 2 || LONG_PRESS_CYC <= DEBOUNCE_CYC) begin : g_bad_params
        $error("clockbox_mode_ctrl: invalid parameter set");
    end

    typedef enum logic [1:0] {StIdle, StRun, StHold} chrono_st_e;

    logic [3:0]     btn_raw;
    logic [3:0]     sync1_q, sync2_q;
    logic [3:0]     deb_q, deb_d;
    logic [DbW-1:0] db_cnt_q [4];
    logic [DbW-1:0] db_cnt_d [4];

    logic power_rise, mode_fall, start_rise, stop_rise;
    logic start_evt, stop_evt;

    logic           disp_en_q, disp_mode_q, disp_page_q;
    logic [LpW-1:0] press_q;
    logic           long_q;
    chrono_st_e     st_q;
    logic           run_q, clear_q;

    assign btn_raw = {btn_stop, btn_start, btn_power, btn_mode};

    // Two-flop synchronizer for the asynchronous raw buttons.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= btn_raw;
            sync2_q <= sync1_q;
        end
    end

    // Debounce: accept a new level only after it has held for DEBOUNCE_CYC cycles.
    always_comb begin
        deb_d = deb_q;
        for (int i = 0; i < 4; i++) begin
            db_cnt_d[i] = '0;
            if (sync2_q[i] != deb_q[i]) begin
                if (db_cnt_q[i] == DbLast) begin
                    deb_d[i] = sync2_q[i];
                end else begin
                    db_cnt_d[i] = db_cnt_q[i] + 1'b1;
                end
            end
        end
    end

    // Debounced levels and their counters.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            deb_q <= '0;
            for (int i = 0; i < 4; i++) db_cnt_q[i] <= '0;
        end else begin
            deb_q <= deb_d;
            for (int i = 0; i < 4; i++) db_cnt_q[i] <= db_cnt_d[i];
        end
    end

    // Strobes fire on the edge where the debounced level changes, so control
    // registers update on that same clock edge.
    assign power_rise = deb_d[BPower] & ~deb_q[BPower];
    assign mode_fall  = ~deb_d[BMode] & deb_q[BMode];
    assign start_rise = deb_d[BStart] & ~deb_q[BStart];
    assign stop_rise  = deb_d[BStop] & ~deb_q[BStop];

    // Panel buttons other than power are inert while the display is off.
    assign start_evt = start_rise & disp_en_q;
    assign stop_evt  = stop_rise & disp_en_q;

    // Power toggle, long-press mode switch and short-press page flip.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            disp_en_q   <= 1'b1;
            disp_mode_q <= 1'b0;
            disp_page_q <= 1'b0;
            press_q     <= '0;
            long_q      <= 1'b0;
        end else begin
            if (power_rise) disp_en_q <= ~disp_en_q;
            if (!disp_en_q) begin
                press_q <= '0;
            end else if (mode_fall) begin
                press_q <= '0;
                long_q  <= 1'b0;
                if (!long_q && !disp_mode_q) disp_page_q <= ~disp_page_q;
            end else if (deb_d[BMode] && press_q != LpMax) begin
                press_q <= press_q + 1'b1;
                // Saturation guarantees a single toggle per press.
                if (press_q == LpLast) begin
                    disp_mode_q <= ~disp_mode_q;
                    long_q      <= 1'b1;
                end
            end
        end
    end

    // Chronometer FSM with registered run level and clear pulse; stop beats start.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            st_q    <= StIdle;
            run_q   <= 1'b0;
            clear_q <= 1'b0;
        end else begin
            clear_q <= 1'b0;
            unique case (st_q)
                StIdle: begin
                    if (start_evt && !stop_evt) begin
                        st_q  <= StRun;
                        run_q <= 1'b1;
                    end
                end
                StRun: begin
                    if (stop_evt) begin
                        st_q  <= StHold;
                        run_q <= 1'b0;
                    end
                end
                StHold: begin
                    if (stop_evt) begin
                        st_q    <= StIdle;
                        clear_q <= 1'b1;
                    end else if (start_evt) begin
                        st_q  <= StRun;
                        run_q <= 1'b1;
                    end
                end
                default: begin
                    st_q  <= StIdle;
                    run_q <= 1'b0;
                end
            endcase
        end
    end

    assign disp_en      = disp_en_q;
    assign disp_mode    = disp_mode_q;
    assign disp_page    = disp_page_q;
    assign chrono_run   = run_q;
    assign chrono_clear = clear_q;

endmodule

// File: doc/clockbox_mode_ctrl.md
Name: clockbox_mode_ctrl

Overview:
Front-panel controller for the clockbox. It conditions the four raw buttons (mode, power, start, stop) and runs the display-mode and chronometer state machines. It emits level and pulse controls to the timekeeping/chrono counters and the column-multiplexed display driver. It sits between io_in[3:0] and the clock/chrono datapath and holds no time values itself.

Parameters:
CLK_HZ, 10000, system clock frequency in Hz; 1 s = CLK_HZ cycles
DEBOUNCE_CYC, 100, cycles a synchronized input must hold a new level before it is accepted (>=2)
LONG_PRESS_CYC, 20000, cycles the debounced mode button must stay high to count as a long press (> DEBOUNCE_CYC)

Ports:
clock  in  1  system clock, single domain
reset  in  1  asynchronous, active-low reset
btn_mode  in  1  raw mode button, active-high, asynchronous to clock
btn_power  in  1  raw power button, active-high, asynchronous
btn_start  in  1  raw chrono start button, active-high, asynchronous
btn_stop  in  1  raw chrono stop button, active-high, asynchronous
disp_en  out  1  1 = display driver enabled (powered)
disp_mode  out  1  0 = time display, 1 = chrono display
disp_page  out  1  time-mode page: 0 = HH:MM, 1 = MM:SS
chrono_run  out  1  level; chrono counter increments while 1
chrono_clear  out  1  one-cycle pulse; chrono counter zeroes

Behaviour:
- Reset (reset=0, asynchronous): disp_en=1, disp_mode=0, disp_page=0, chrono_run=0, chrono_clear=0. Chrono FSM=IDLE. Sync/debounce flops=0. Debounce/long-press counters=0. long_done=0.
- Input conditioning, per button: 2-flop synchronizer, then debouncer.
  - Debounce counter clears whenever sync==deb.
  - Counter increments while sync!=deb. When it reaches DEBOUNCE_CYC-1, deb<=sync and the counter clears.
  - Net: a clean raw edge appears on deb exactly 2+DEBOUNCE_CYC cycles later. Glitches shorter than DEBOUNCE_CYC are rejected.
  - Rise/fall strobes are one cycle wide, derived from deb vs its previous value.
- Power: each power rise toggles disp_en. While disp_en=0:
  - mode/start/stop strobes are ignored and the long-press counter is held at 0.
  - chrono_run keeps its value, so the chrono continues counting in the background.
  - disp_mode and disp_page are retained.
- Mode button:
  - press_cnt counts cycles while mode deb=1 and saturates at LONG_PRESS_CYC.
  - On the cycle press_cnt reaches LONG_PRESS_CYC: toggle disp_mode and set long_done. Only one toggle per press, however long it is held.
  - On mode fall: if long_done=0 and disp_mode=0, toggle disp_page. A short press in chrono mode has no effect.
  - On mode fall, always clear press_cnt and long_done.
- Chrono FSM: states IDLE, RUN, HOLD. It runs independently of disp_mode, so it is operable and keeps state in either display mode.
  - IDLE: start rise -> RUN.
  - RUN: stop rise -> HOLD.
  - HOLD: start rise -> RUN (resume); stop rise -> IDLE with chrono_clear=1 for exactly that cycle.
  - Start and stop rise in the same cycle: stop wins. IDLE stays IDLE, no clear.
  - chrono_run=1 iff state==RUN (registered, same cycle as the state).
- All outputs are registered; no combinational path from btn_* to outputs.
- Reset mid-press or mid-debounce: everything returns to reset values. A button still held after reset release must re-debounce, then rise normally. A long press already in progress restarts its count from 0.

Test Plan:
- Reset with all buttons low -> disp_en=1, disp_mode=0, disp_page=0, chrono_run=0, chrono_clear never pulses over 10000 cycles.
- Mode high 20000 cycles, then low (defaults) -> disp_mode goes 0->1 exactly 2+100+20000-1 cycles after the raw rise; no further toggle; disp_page unchanged on release.
- Mode pulse of 5000 cycles in time mode -> disp_page 0->1 at 2+100 cycles after the raw fall. A 50-cycle glitch -> no change.
- Chrono mode: start high 30000 cycles -> chrono_run=1 from 102 cycles after the raw rise. Then stop -> chrono_run=0 (HOLD). Second stop press -> single-cycle chrono_clear, state IDLE.
- chrono_run=1, long mode press to time mode -> chrono_run stays 1. Power press -> disp_en=0. Start/stop presses while off -> chrono_run unchanged. Second power press -> disp_en=1.
- Start and stop raw edges on the same cycle from IDLE -> state IDLE, chrono_run=0, no clear. reset asserted mid long press (cycle 15000) -> all outputs at reset values; after release, held mode needs the full 20000+ cycles to toggle.
